// File: rtl/mem_port_arbiter.sv
// Shared instruction/data memory arbiter: IF vs DM request/grant with a fixed-latency access sequencer.
// Optional wait-cycle counters are enabled by defining ARB_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | no transaction; grants are issued here only
// ACCESS | memory strobes active for MEM_LAT cycles (lat_cnt counts down)
// RESP   | owner's rvalid pulses for one cycle
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [2:0]        dm_funct3,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic [31:0]       if_wait_cnt,
  output logic [31:0]       dm_wait_cnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] LAT_LD     = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  state_t            state, state_nxt;
  logic [2:0]        lat_cnt;
  logic [3:0]        streak;
  logic              owner_dm, we_q, kill_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rd_q, if_rdata_q, dm_rdata_q;
  logic [2:0]        funct3_q;
  logic              lat_tc;

  assign lat_tc = (lat_cnt == 3'd0);

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    case (state)
      IDLE: begin
        dm_gnt = dm_req && (!if_req || streak != STARVE_MAX);
        if_gnt = if_req && !dm_gnt;
        if (if_gnt || dm_gnt) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_read  = ~we_q;
        mem_write = we_q && (lat_cnt == LAT_LD);
        if (lat_tc) state_nxt = RESP;
      end
      RESP: begin
        // a flush arriving in the RESP cycle itself must still suppress the fetch
        if_rvalid = !owner_dm && !kill_q && !if_flush;
        dm_rvalid = owner_dm;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      streak     <= '0;
      owner_dm   <= 1'b0;
      we_q       <= 1'b0;
      kill_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state <= state_nxt;

      if (if_gnt || dm_gnt) begin
        owner_dm <= dm_gnt;
        addr_q   <= dm_gnt ? dm_addr : if_addr;
        we_q     <= dm_gnt && dm_we;
        funct3_q <= dm_gnt ? dm_funct3 : 3'b010;
        lat_cnt  <= LAT_LD;
        if (dm_gnt) wdata_q <= dm_wdata;
      end else if (state == ACCESS && !lat_tc) begin
        lat_cnt <= lat_cnt - 3'd1;
      end

      if (state == ACCESS && lat_tc && !we_q) rd_q <= mem_rdata;
      if (if_rvalid) if_rdata_q <= rd_q;
      if (dm_rvalid && !we_q) dm_rdata_q <= rd_q;

      if (state == RESP)
        kill_q <= 1'b0;
      else if (if_flush && (if_gnt || (state == ACCESS && !owner_dm)))
        kill_q <= 1'b1;

      if (!if_req || if_gnt)
        streak <= '0;
      else if (dm_gnt && streak != STARVE_MAX)
        streak <= streak + 4'd1;
    end
  end

  assign if_rdata   = if_rvalid ? rd_q : if_rdata_q;
  assign dm_rdata   = (dm_rvalid && !we_q) ? rd_q : dm_rdata_q;
  assign mem_addr   = addr_q;
  assign mem_funct3 = funct3_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state != IDLE);

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_wait_cnt <= '0;
      dm_wait_cnt <= '0;
    end else begin
      if (if_req && !if_gnt) if_wait_cnt <= if_wait_cnt + 32'd1;
      if (dm_req && !dm_gnt) dm_wait_cnt <= dm_wait_cnt + 32'd1;
    end
  end
`else
  assign if_wait_cnt = '0;
  assign dm_wait_cnt = '0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-ported instruction/data memory between two requesters: the fetch stage (IF) and the MEM-stage load/store port (DM).
- Replaces clock-phase multiplexing of the shared memory with an explicit request/grant/response handshake and a fixed-latency access sequencer.
- Sits between the pipeline (PC/IF_ID logic and EX_MEM load/store signals) and the data memory instance.

Parameters:
- ADDR_W, 9, byte-address width presented to the memory.
- MEM_LAT, 1, number of ACCESS cycles per transaction; legal range 1..7.
- STARVE_LIM, 2, maximum consecutive DM grants while IF waits; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  branch redirect; kills any in-flight fetch response.
- if_gnt  out  1  fetch accepted (combinational, IDLE only).
- if_rvalid  out  1  one-cycle pulse, if_rdata valid.
- if_rdata  out  32  fetched word.
- dm_req  in  1  data request; held until dm_gnt.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  32  store data.
- dm_funct3  in  3  access size/sign code, passed to memory.
- dm_gnt  out  1  data request accepted (combinational, IDLE only).
- dm_rvalid  out  1  one-cycle completion pulse (loads and stores).
- dm_rdata  out  32  load data; updated on loads only.
- mem_addr  out  ADDR_W  memory address.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_funct3  out  3  memory size code.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid combinationally while mem_read=1.
- busy  out  1  high in ACCESS or RESP.

Behaviour:
- Reset: state=IDLE, streak=0, owner=IF. All outputs 0, including rdata registers. Reset is asynchronous and overrides every other input. mem_read and mem_write drop immediately, so an interrupted access never completes and raises no rvalid.
- States and transitions:
  - IDLE -> ACCESS when any request is granted; otherwise stay in IDLE.
  - ACCESS lasts exactly MEM_LAT cycles (counter lat_cnt), then -> RESP.
  - RESP lasts 1 cycle, then -> IDLE. Grants are issued only in IDLE.
- Arbitration (IDLE):
  - Only one request: grant it.
  - Both requests: DM wins, unless streak==STARVE_LIM, in which case IF wins.
  - streak increments on a DM grant while if_req=1, saturating at STARVE_LIM. It clears on an IF grant, and clears on any cycle with if_req=0.
- On grant: latch owner, addr, we, wdata and funct3. IF grants always latch we=0 and funct3=3'b010. The requester may change its inputs from the next cycle.
- ACCESS outputs:
  - mem_addr, mem_funct3 and mem_wdata are driven from the latched values.
  - mem_read=~we for all MEM_LAT cycles.
  - mem_write=we only in the first ACCESS cycle (exactly one write).
  - Outside ACCESS, mem_read=mem_write=0 and the other mem_* outputs hold their last latched value.
- Read data is captured from mem_rdata at the end of the last ACCESS cycle.
- Latency: grant in cycle N; ACCESS in N+1..N+MEM_LAT; rvalid in cycle N+MEM_LAT+1. Peak throughput is one transaction per MEM_LAT+2 cycles.
- RESP:
  - Asserts the owner's rvalid for 1 cycle. if_rdata or dm_rdata hold their value until the next load response of that port.
  - Store: dm_rvalid pulses and dm_rdata is unchanged.
- Flush:
  - A sticky kill flag sets if if_flush=1 in any cycle from grant through RESP of an IF-owned transaction, including the grant cycle.
  - A killed fetch still completes its memory access, but if_rvalid stays 0 and if_rdata is not updated.
  - The kill flag clears on entering IDLE.
  - if_flush has no effect on DM transactions.
- A requester that deasserts req before gnt is not granted; there is no penalty.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined: two 32-bit wrap-around counters, if_wait_cnt and dm_wait_cnt, on extra output ports. Each counts cycles with req=1 and gnt=0 for its port, and both clear on rst.
- When undefined: the ports still exist, tie to 0, and no counter flops are synthesized.

Test Plan:
- Single fetch (MEM_LAT=1): if_req=1, if_addr=0x010 in cycle 0 -> if_gnt in cycle 0; mem_read=1, mem_addr=0x010, mem_funct3=010 in cycle 1; if_rvalid=1 with if_rdata=0x00500093 in cycle 2.
- Contention: if_req=dm_req=1 in the same IDLE cycle -> dm_gnt first; if_gnt at the next IDLE (cycle 3).
- Starvation (STARVE_LIM=2): dm_req and if_req held high continuously -> grant sequence D,D,I,D,D,I.
- Store: dm_we=1, dm_addr=0x040, dm_wdata=0xDEADBEEF, dm_funct3=010 -> mem_write high for exactly 1 cycle; dm_rvalid pulse; dm_rdata unchanged from its prior load value.
- Flush: fetch of 0x020 granted, if_flush=1 during ACCESS -> mem_read still occurs; no if_rvalid; a following fetch of 0x030 returns normally.
- Reset mid-access: rst asserted during ACCESS of a store -> mem_write=0 immediately; no rvalid; busy=0; after release, a fetch of 0x000 completes in MEM_LAT+1 cycles.
